// File: rtl/ct_ifu_mbist_pkg.sv
// Shared encodings for the predecode-array March C- BIST sequencer.
package ct_ifu_mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0_UP   = 3'd1,
    ST_R0W1_UP = 3'd2,
    ST_R1W0_DN = 3'd3,
    ST_R0_DN   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } mbist_state_e;

  typedef enum logic [1:0] {
    ME_W0_UP   = 2'd0,
    ME_R0W1_UP = 2'd1,
    ME_R1W0_DN = 2'd2,
    ME_R0_DN   = 2'd3
  } march_elem_e;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_LAST  = (1 << DEF_ADDR_WIDTH) - 1;

endpackage

// File: rtl/ct_ifu_predecd_mbist_ctrl_if.sv
// Single-port predecode array access bus driven by the BIST sequencer.
interface ct_ifu_predecd_mbist_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_index;
  logic                  mem_cen_b;
  logic                  mem_wen_b;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (output mem_index, mem_cen_b, mem_wen_b, mem_din, input mem_dout);
  modport slave  (input mem_index, mem_cen_b, mem_wen_b, mem_din, output mem_dout);
endinterface

// File: rtl/ct_ifu_mbist_cmp.sv
// Read-compare pipeline: registers expected data/index of each read, compares
// dout one cycle later, and captures the first failing index and data.
module ct_ifu_mbist_cmp #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  mismatch,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  always_comb begin
    mismatch = vld_q && (dout !== exp_q);
    // A read issued in the aborting cycle must not be compared afterwards.
    vld_d    = rd_vld && !mismatch;
    idx_d    = rd_idx;
    exp_d    = rd_exp;
    fail_d   = fail_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    if (clr) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      fdata_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_d  = 1'b1;
      faddr_d = idx_q;
      fdata_d = dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      idx_q   <= '0;
      exp_q   <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign fail      = fail_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;
endmodule

// File: rtl/ct_ifu_predecd_mbist_ctrl.sv
// March C- BIST sequencer for the I-cache predecode SRAM (1-cycle read latency).
// The registered access fields always describe the access presented this cycle.
module ct_ifu_predecd_mbist_ctrl
  import ct_ifu_mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_LAST  = 2**ADDR_WIDTH - 1
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    bist_start,
  input  logic [DATA_WIDTH-1:0]   bist_bg,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_fail,
  output logic [ADDR_WIDTH-1:0]   bist_fail_addr,
  output logic [DATA_WIDTH-1:0]   bist_fail_data,
  ct_ifu_predecd_mbist_ctrl_if.master mem
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_LAST);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  mbist_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  wr_ph_q, wr_ph_d;
  logic                  cen_q, cen_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] bg_q, bg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_acc;
  logic                  mismatch;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_exp;

  assign rd_vld = !cen_q && wen_q;
  assign rd_exp = (state_q == ST_R1W0_DN) ? ~bg_q : bg_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_ph_d   = 1'b0;
    cen_d     = 1'b1;
    wen_d     = 1'b1;
    din_d     = din_q;
    bg_d      = bg_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          start_acc = 1'b1;
          bg_d      = bist_bg;
          state_d   = ST_W0_UP;
          idx_d     = '0;
          cen_d     = 1'b0;
          wen_d     = 1'b0;
          din_d     = bist_bg;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      ST_W0_UP: begin
        cen_d = 1'b0;
        if (idx_q == LAST) begin
          state_d = ST_R0W1_UP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ONE;
          wen_d = 1'b0;
          din_d = bg_q;
        end
      end
      ST_R0W1_UP: begin
        cen_d = 1'b0;
        if (!wr_ph_q) begin
          wr_ph_d = 1'b1;
          wen_d   = 1'b0;
          din_d   = ~bg_q;
        end else if (idx_q == LAST) begin
          state_d = ST_R1W0_DN;
          idx_d   = LAST;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_R1W0_DN: begin
        cen_d = 1'b0;
        if (!wr_ph_q) begin
          wr_ph_d = 1'b1;
          wen_d   = 1'b0;
          din_d   = bg_q;
        end else if (idx_q == '0) begin
          state_d = ST_R0_DN;
          idx_d   = LAST;
        end else begin
          idx_d = idx_q - ONE;
        end
      end
      ST_R0_DN: begin
        if (idx_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          cen_d = 1'b0;
          idx_d = idx_q - ONE;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // First mismatch: the access already on the port finishes, nothing follows.
    if (mismatch) begin
      state_d = ST_DONE;
      cen_d   = 1'b1;
      wen_d   = 1'b1;
      wr_ph_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_ph_q <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      din_q   <= '0;
      bg_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_ph_q <= wr_ph_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      din_q   <= din_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ct_ifu_mbist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .clr       (start_acc),
    .rd_vld    (rd_vld),
    .rd_idx    (idx_q),
    .rd_exp    (rd_exp),
    .dout      (mem.mem_dout),
    .mismatch  (mismatch),
    .fail      (bist_fail),
    .fail_addr (bist_fail_addr),
    .fail_data (bist_fail_data)
  );

  assign mem.mem_index = idx_q;
  assign mem.mem_cen_b = cen_q;
  assign mem.mem_wen_b = wen_q;
  assign mem.mem_din   = din_q;
  assign bist_busy     = busy_q;
  assign bist_done     = done_q;
endmodule

// File: tb/tb_ct_ifu_predecd_mbist_ctrl.sv
// Directed bench: three sequencers (ADDR_LAST 7, 3, 0) each on a small array model.
module tb_ct_ifu_predecd_mbist_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [31:0] bg;
  logic        stuck_en;

  logic [2:0]  cen_o, wen_o, busy_o, done_o, fail_o;
  logic [15:0] idx_o   [3];
  logic [15:0] faddr_o [3];
  logic [31:0] din_o   [3];
  logic [31:0] fdata_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AL = (g == 0) ? 7 : ((g == 1) ? 3 : 0);
    logic [31:0] mem [0:7];

    ct_ifu_predecd_mbist_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) mif ();

    ct_ifu_predecd_mbist_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ADDR_LAST(AL)) u_dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bist_start     (start[g]),
      .bist_bg        (bg),
      .bist_busy      (busy_o[g]),
      .bist_done      (done_o[g]),
      .bist_fail      (fail_o[g]),
      .bist_fail_addr (faddr_o[g]),
      .bist_fail_data (fdata_o[g]),
      .mem            (mif)
    );

    // Array model; instance 0 can have bit 5 of index 4 stuck at 1.
    always @(posedge clk) begin
      if (!mif.mem_cen_b) begin
        if (!mif.mem_wen_b)
          mem[mif.mem_index[2:0]] <= mif.mem_din;
        else
          mif.mem_dout <= mem[mif.mem_index[2:0]] |
                          ((g == 0 && stuck_en && mif.mem_index == 16'd4) ? 32'h20 : 32'h0);
      end
    end

    assign cen_o[g]   = mif.mem_cen_b;
    assign wen_o[g]   = mif.mem_wen_b;
    assign idx_o[g]   = mif.mem_index;
    assign din_o[g]   = mif.mem_din;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts instance s with background b (cycle 0 = start cycle) and traces its accesses.
  task automatic run(input int s, input logic [31:0] b, input int al, input int pulse_cyc,
                     input int rst_cyc, output int n_acc, output int done_cyc,
                     output int last_acc, output int ord_err);
    logic [48:0] exp_q[$];
    logic [48:0] e;
    int k;
    for (int i = 0; i <= al; i++) exp_q.push_back({1'b0, 16'(i), b});
    for (int i = 0; i <= al; i++) begin
      exp_q.push_back({1'b1, 16'(i), 32'h0});
      exp_q.push_back({1'b0, 16'(i), ~b});
    end
    for (int i = al; i >= 0; i--) begin
      exp_q.push_back({1'b1, 16'(i), 32'h0});
      exp_q.push_back({1'b0, 16'(i), b});
    end
    for (int i = al; i >= 0; i--) exp_q.push_back({1'b1, 16'(i), 32'h0});
    n_acc = 0; done_cyc = -1; last_acc = -1; ord_err = 0; k = 0;
    @(posedge clk); #1;
    bg = b;
    start[s] = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start[s] = (c == pulse_cyc);
      if (c == 1) bg = 32'hDEAD_BEEF;
      if (!cen_o[s]) begin
        n_acc++;
        last_acc = c;
        if (k < exp_q.size()) begin
          e = exp_q[k];
          if (wen_o[s] !== e[48] || idx_o[s] !== e[47:32] || (!wen_o[s] && din_o[s] !== e[31:0]))
            ord_err++;
        end else begin
          ord_err++;
        end
        k++;
      end
      if (c == rst_cyc) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cen", cen_o[s], 1);
        chk("rst_mid_wen", wen_o[s], 1);
        chk("rst_mid_busy", busy_o[s], 0);
        break;
      end
      if (done_o[s] && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
  endtask

  initial begin
    int acc, dc, la, oe;
    rst_n = 1'b0; start = 3'b000; bg = 32'h0; stuck_en = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cen", cen_o[0], 1);
    chk("rst_wen", wen_o[0], 1);
    chk("rst_idx", idx_o[0], 0);
    chk("rst_din", din_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_done", done_o[0], 0);
    chk("rst_fail", fail_o[0], 0);
    chk("rst_faddr", faddr_o[0], 0);
    chk("rst_fdata", fdata_o[0], 0);

    // Fault-free, 8 entries, bg 0
    run(0, 32'h0, 7, -1, -1, acc, dc, la, oe);
    chk("t1_acc", acc, 48);
    chk("t1_last_acc", la, 48);
    chk("t1_done_cyc", dc, 50);
    chk("t1_order", oe, 0);
    chk("t1_fail", fail_o[0], 0);
    chk("t1_busy", busy_o[0], 0);

    // Checkerboard background, 4 entries
    run(1, 32'hA5A5_5A5A, 3, -1, -1, acc, dc, la, oe);
    chk("t2_acc", acc, 24);
    chk("t2_done_cyc", dc, 26);
    chk("t2_order", oe, 0);
    chk("t2_fail", fail_o[1], 0);

    // Stuck-at-1 on bit 5 of index 4: caught at the first read of index 4 (cycle 17)
    stuck_en = 1'b1;
    run(0, 32'h0, 7, -1, -1, acc, dc, la, oe);
    chk("t3_acc", acc, 18);
    chk("t3_last_acc", la, 18);
    chk("t3_done_cyc", dc, 19);
    chk("t3_order", oe, 0);
    chk("t3_fail", fail_o[0], 1);
    chk("t3_faddr", faddr_o[0], 4);
    chk("t3_fdata", fdata_o[0], 32'h20);
    chk("t3_busy", busy_o[0], 0);
    chk("t3_done", done_o[0], 1);

    // Restart from a failed DONE with a start pulse during R1W0_DN that must be ignored
    stuck_en = 1'b0;
    run(0, 32'h0, 7, 30, -1, acc, dc, la, oe);
    chk("t4_acc", acc, 48);
    chk("t4_done_cyc", dc, 50);
    chk("t4_order", oe, 0);
    chk("t4_fail", fail_o[0], 0);
    chk("t4_faddr", faddr_o[0], 0);
    chk("t4_fdata", fdata_o[0], 0);

    // Asynchronous reset during R0W1_UP, then a clean rerun
    run(0, 32'h0, 7, -1, 12, acc, dc, la, oe);
    #3 rst_n = 1'b1;
    run(0, 32'h0F0F_00FF, 7, -1, -1, acc, dc, la, oe);
    chk("t5_acc", acc, 48);
    chk("t5_done_cyc", dc, 50);
    chk("t5_order", oe, 0);
    chk("t5_fail", fail_o[0], 0);

    // Single-entry array
    run(2, 32'h1234_5678, 0, -1, -1, acc, dc, la, oe);
    chk("t6_acc", acc, 6);
    chk("t6_done_cyc", dc, 8);
    chk("t6_order", oe, 0);
    chk("t6_fail", fail_o[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
